// File: rtl/next_pc_unit.sv
// Next-PC generator: sequential advance, branch/jump/register-jump redirects,
// a one-entry pending buffer for redirects accepted while stalled, and misalignment faults.
module next_pc_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned JIDX_W = 26,
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned SHIFT  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redir_valid,
    input  logic [1:0]        redir_mode,
    input  logic [ADDR_W-1:0] redir_base,
    input  logic [JIDX_W-1:0] jidx,
    input  logic [IMM_W-1:0]  imm,
    input  logic [ADDR_W-1:0] rs_val,
    output logic              redir_ack,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_next_seq,
    output logic              misalign_fault,
    output logic [ADDR_W-1:0] fault_addr
);

    localparam int unsigned       JLO_W      = JIDX_W + SHIFT;
    localparam logic [ADDR_W-1:0] INC        = ADDR_W'(1) << SHIFT;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = INC - ADDR_W'(1);
    // Upper PC bits kept by a jump; empty when the index fills the whole PC.
    localparam logic [ADDR_W-1:0] JMASK      = ~((ADDR_W'(1) << JLO_W) - ADDR_W'(1));

    localparam logic [1:0] MODE_BR = 2'b00;
    localparam logic [1:0] MODE_J  = 2'b01;
    localparam logic [1:0] MODE_JR = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    logic [ADDR_W-1:0] r_pc;
    logic              r_pend_valid;
    logic [ADDR_W-1:0] r_pend_target;
    logic              r_fault;
    logic [ADDR_W-1:0] r_fault_addr;

    logic [ADDR_W-1:0] w_imm_ext;
    logic [ADDR_W-1:0] w_jump;
    logic [ADDR_W-1:0] w_branch;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_pc_seq;
    logic              w_ack;
    logic              w_misalign;
    logic              w_take;
    logic              w_fault_take;

    assign w_imm_ext = ADDR_W'($signed(imm));
    assign w_jump    = (redir_base & JMASK) | (ADDR_W'(jidx) << SHIFT);
    assign w_branch  = redir_base + (w_imm_ext << SHIFT);
    assign w_pc_seq  = r_pc + INC;

    // Target select by redirect mode
    always_comb begin
        w_target = rs_val;
        case (redir_mode)
            MODE_BR: w_target = w_branch;
            MODE_J:  w_target = w_jump;
            default: w_target = rs_val;
        endcase
    end

    assign w_ack        = redir_valid & ~r_pend_valid;
    assign w_misalign   = (redir_mode == MODE_JR) && ((rs_val & ALIGN_MASK) != '0);
    assign w_take       = w_ack & (redir_mode != MODE_RSV) & ~w_misalign;
    assign w_fault_take = w_ack & w_misalign;

    // PC and pending-buffer update; the pending target always wins once the stall lifts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
        end else if (!stall && r_pend_valid) begin
            r_pc         <= r_pend_target;
            r_pend_valid <= 1'b0;
        end else if (w_take && !stall) begin
            r_pc <= w_target;
        end else if (w_take && stall) begin
            r_pend_target <= w_target;
            r_pend_valid  <= 1'b1;
        end else if (!stall) begin
            r_pc <= w_pc_seq;
        end
    end

    // Fault pulse and sticky address of the last misaligned register jump
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
        end else begin
            r_fault <= w_fault_take;
            if (w_fault_take) begin
                r_fault_addr <= rs_val;
            end
        end
    end

    assign redir_ack      = w_ack;
    assign pc_out         = r_pc;
    assign pc_next_seq    = w_pc_seq;
    assign misalign_fault = r_fault;
    assign fault_addr     = r_fault_addr;

endmodule
